// File: rtl/tone_synth_if.sv
// -----------------------------------------------------------------------------
// tone_synth_if -- note handshake between the melody sequencer and tone_synth.
//
// Signals:
//   note_valid   sequencer -> synth : a note is offered
//   note_ready   synth -> sequencer : the synth can take a note this cycle
//   note_period  sequencer -> synth : half-period in clk cycles (0 = rest)
//   note_len     sequencer -> synth : duration in ticks (0 = discard)
//
// Modports:
//   master : the sequencer side (drives the note)
//   slave  : the tone_synth side (accepts the note)
// -----------------------------------------------------------------------------
interface tone_synth_if #(
  parameter int PER_W = 16
);
  logic             note_valid;
  logic             note_ready;
  logic [PER_W-1:0] note_period;
  logic [7:0]       note_len;

  modport master (
    output note_valid,
    output note_period,
    output note_len,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_period,
    input  note_len,
    output note_ready
  );
endinterface

// File: rtl/tone_synth.sv
// -----------------------------------------------------------------------------
// tone_synth -- note-to-speaker tone stage.
//
// Accepts one note at a time (half-period + duration in ticks) and drives the
// complementary speaker pair with a square wave for exactly len*TICK_DIV
// cycles, then returns to IDLE and pulses done for one cycle.
//
// Parameters:
//   TICK_DIV  clk cycles per duration tick (>= 2)
//   PER_W     width of note_period
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous, active-high reset
//   note_if   slave side of the note handshake (valid/ready/period/len)
//   speaker   {~phase, phase} while sounding, 2'b00 when silent (registered)
//   busy      high whenever not IDLE (registered)
//   done      one-cycle pulse when a note completes or is discarded
//
// Build option:
//   TONE_GAP_EN  when defined, one tick of silence (GAP state) follows every
//                played note before done is pulsed.
// -----------------------------------------------------------------------------
module tone_synth #(
  parameter int TICK_DIV = 100,
  parameter int PER_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  tone_synth_if.slave  note_if,
  output logic [1:0]   speaker,
  output logic         busy,
  output logic         done
);

  localparam int TC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
`ifdef TONE_GAP_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif

  logic [1:0]       state;
  logic [PER_W-1:0] per;
  logic [PER_W-1:0] hc;
  logic [7:0]       rem;
  logic [TC_W-1:0]  tc;
  logic             phase;

  logic accept;
  logic tick_wrap;
  logic half_wrap;
  logic last_cycle;
  logic phase_n;

  // NOTE: note_ready is combinational so that reset suppresses an accept in
  // the very cycle rst is raised, not one cycle later.
  assign note_if.note_ready = (state == IDLE) && !rst;
  assign accept             = note_if.note_valid && note_if.note_ready;

  assign tick_wrap  = (tc == TC_W'(TICK_DIV - 1));
  // A rest (per==0) never wraps, which freezes hc and phase.
  assign half_wrap  = (per != '0) && (hc == per - PER_W'(1));
  assign last_cycle = tick_wrap && (rem == 8'd1);
  // Phase as it will be next cycle; speaker is registered from it so the
  // output lines up with the counters rather than lagging by one cycle.
  assign phase_n    = half_wrap ? ~phase : phase;

  // NOTE: every state element uses non-blocking assignments so all registers
  // update from the same pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      per     <= '0;
      hc      <= '0;
      rem     <= '0;
      tc      <= '0;
      phase   <= 1'b0;
      speaker <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            per   <= note_if.note_period;
            rem   <= note_if.note_len;
            hc    <= '0;
            tc    <= '0;
            phase <= 1'b0;
            if (note_if.note_len == 8'd0) begin
              // Discarded note: stay idle, just acknowledge it.
              done <= 1'b1;
            end else begin
              state   <= PLAY;
              busy    <= 1'b1;
              speaker <= (note_if.note_period != '0) ? 2'b10 : 2'b00;
            end
          end
        end

        PLAY: begin
          if (half_wrap) begin
            phase <= ~phase;
            hc    <= '0;
          end else if (per != '0) begin
            hc <= hc + PER_W'(1);
          end

          if (tick_wrap) begin
            tc  <= '0;
            rem <= rem - 8'd1;
          end else begin
            tc <= tc + TC_W'(1);
          end

          if (last_cycle) begin
            speaker <= 2'b00;
`ifdef TONE_GAP_EN
            state   <= GAP;
`else
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            speaker <= (per != '0) ? {~phase_n, phase_n} : 2'b00;
          end
        end

`ifdef TONE_GAP_EN
        GAP: begin
          // tc was wrapped to 0 on the last PLAY cycle, so this is one tick.
          if (tick_wrap) begin
            tc    <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tc <= tc + TC_W'(1);
          end
        end
`endif

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          speaker <= 2'b00;
        end
      endcase
    end
  end

endmodule
